// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the LSU and data memory.
// master: req/addr/wen/wdata out, ready/rdata in; slave: the reverse.
interface lsu_mem_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_wen;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_addr, dm_wen, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_addr, dm_wen, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store unit at EXE->MEM: blocking req/ready access, lanes, load extension.
// Ports: clk, rst (sync active-low), enable/opcode/funct3/addr/store_data in,
// dm (memory bus master), load_data/done/stall/misalign out.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module lsu_mem_access #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  lsu_mem_access_if.master  dm,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              stall,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state;

  logic       is_ld;
  logic       is_st;
  logic       start;
  logic       ok_c;
  logic       mis_c;
  logic [3:0] wen_c;
  logic [DATA_W-1:0] wdata_c;

  logic       ld_q;
  logic [2:0] f3_q;
  logic [1:0] o_q;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [DATA_W-1:0] ld_ext;

  assign is_ld = (opcode == 7'b0000011);
  assign is_st = (opcode == 7'b0100011);
  assign start = enable & (is_ld | is_st) & (state == IDLE);
  assign stall = start | (state == REQ);

  // Loads allow 000/001/010/100/101, stores 000/001/010.
  assign ok_c = is_ld ? (funct3 != 3'b011) && (funct3[2:1] != 2'b11)
                      : (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c = ((funct3[1:0] == 2'b01) & addr[0])
               | ((funct3[1:0] == 2'b10) & (|addr[1:0]));
`else
  assign mis_c = 1'b0;
`endif

  always_comb begin
    wen_c   = 4'b0000;
    wdata_c = '0;
    if (is_st) begin
      unique case (1'b1)
        (funct3[1:0] == 2'b00): begin
          wen_c   = 4'b0001 << addr[1:0];
          wdata_c = {4{store_data[7:0]}};
        end
        (funct3[1:0] == 2'b01): begin
          wen_c   = 4'b0011 << {addr[1], 1'b0};
          wdata_c = {2{store_data[15:0]}};
        end
        (funct3[1:0] == 2'b10): begin
          wen_c   = 4'b1111;
          wdata_c = store_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rb = dm.dm_rdata[7:0];
    unique case (o_q)
      2'd0: rb = dm.dm_rdata[7:0];
      2'd1: rb = dm.dm_rdata[15:8];
      2'd2: rb = dm.dm_rdata[23:16];
      2'd3: rb = dm.dm_rdata[31:24];
      default: ;
    endcase
    rh = o_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
  end

  always_comb begin
    ld_ext = '0;
    if (ld_q) begin
      unique case (1'b1)
        (f3_q == 3'b000): ld_ext = {{(DATA_W-8){rb[7]}}, rb};
        (f3_q == 3'b001): ld_ext = {{(DATA_W-16){rh[15]}}, rh};
        (f3_q == 3'b010): ld_ext = dm.dm_rdata;
        (f3_q == 3'b100): ld_ext = {{(DATA_W-8){1'b0}}, rb};
        (f3_q == 3'b101): ld_ext = {{(DATA_W-16){1'b0}}, rh};
        default: ld_ext = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      dm.dm_req   <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wen   <= 4'b0000;
      dm.dm_wdata <= '0;
      load_data   <= '0;
      done        <= 1'b0;
      ld_q        <= 1'b0;
      f3_q        <= 3'b000;
      o_q         <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!ok_c || mis_c) begin
              // Rejected access: complete without touching memory.
              state     <= DONE;
              done      <= 1'b1;
              load_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
              misalign  <= ok_c & mis_c;
`endif
            end else begin
              state       <= REQ;
              dm.dm_req   <= 1'b1;
              dm.dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
              dm.dm_wen   <= wen_c;
              dm.dm_wdata <= wdata_c;
              ld_q        <= is_ld;
              f3_q        <= funct3;
              o_q         <= addr[1:0];
            end
          end
        end
        REQ: begin
          if (dm.dm_ready) begin
            state     <= DONE;
            dm.dm_req <= 1'b0;
            dm.dm_wen <= 4'b0000;
            done      <= 1'b1;
            load_data <= ld_ext;
          end
        end
        DONE: begin
          state     <= IDLE;
          load_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

endmodule
